// File: rtl/parameterized_serializer_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Beat index width; SIZE >= 2 keeps this at one bit or more.
  function automatic int cnt_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/parameterized_serializer_bit_counter.sv
// Saturating beat counter with synchronous clear and a terminal-count flag.
module bit_counter #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over inc; inc is ignored at MAX so the count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign terminal = (r_count == MAX);

endmodule

// File: rtl/parameterized_serializer.sv
// Parallel-in, serial-out reader: one word per load handshake, one bit per serial beat.
module parameterized_serializer
  import serializer_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE-1:0]            d,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic                       ser_out,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic                       ser_last,
  output logic                       done,
  output ser_state_t                 o_dbg_state,
  output logic [cnt_width(SIZE)-1:0] o_dbg_count
);

  localparam int CW = cnt_width(SIZE);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. load_ready/ser_valid depend on state only; once ser_valid rises,
  // ser_out/ser_last hold until the beat is accepted.

  ser_state_t      r_state;
  ser_state_t      w_next_state;
  logic [SIZE-1:0] r_shreg;
  logic            r_done;
  logic            w_load;
  logic            w_beat;
  logic            w_last_beat;
  logic            w_terminal;
  logic [CW-1:0]   w_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_beat       = 1'b0;
    w_last_beat  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          w_beat = 1'b1;
          if (w_terminal) begin
            w_last_beat  = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  bit_counter #(
    .WIDTH (CW),
    .MAX   (CW'(SIZE - 1))
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_load | w_last_beat),
    .inc      (w_beat & ~w_terminal),
    .count    (w_count),
    .terminal (w_terminal)
  );

  // Zeroing on the final beat keeps ser_out low while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= d;
    end else if (w_last_beat) begin
      r_shreg <= '0;
    end else if (w_beat) begin
      r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_beat;
    end
  end

  assign load_ready  = (r_state == IDLE);
  assign ser_valid   = (r_state == SHIFT);
  assign ser_out     = LSB_FIRST ? r_shreg[0] : r_shreg[SIZE-1];
  assign ser_last    = (r_state == SHIFT) & w_terminal;
  assign done        = r_done;
  assign o_dbg_state = r_state;
  assign o_dbg_count = w_count;

endmodule

// File: doc/parameterized_serializer.md
Name: parameterized_serializer

Overview:
- Parallel-in, serial-out reader for a SIZE-bit word held in a register.
- Accepts one word per valid/ready handshake, then shifts it out one bit per accepted serial beat.
- Serial beats use their own valid/ready handshake, with a last-bit flag.
- Sits downstream of enable-loaded registers, e.g. for debug/scan readout of the register file or a pipeline register.

Parameters:
SIZE, 32, word width in bits; legal range SIZE >= 2.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit SIZE-1 is sent first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
d  input  SIZE  parallel word to serialize.
load_valid  input  1  d is valid this cycle.
load_ready  output  1  block can accept a word.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_ready  input  1  consumer accepts ser_out this cycle.
ser_last  output  1  current beat is the final bit of the word.
done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset asserted (reset=0) forces, immediately and independent of clk:
  - state=IDLE, shift register=0, bit counter=0;
  - load_ready=1, ser_valid=0, ser_out=0, ser_last=0, done=0.
- Reset asserted mid-word aborts the word; no partial completion and no done pulse. After release the block is in IDLE.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0.
  - Load occurs when load_valid=1 at a clk edge: d is captured into the shift register, counter=0, next state SHIFT.
  - load_valid with any d is ignored outside IDLE; load_ready=0 there.
- SHIFT:
  - ser_valid=1; load_ready=0.
  - ser_out = shreg[0] if LSB_FIRST else shreg[SIZE-1]. It is registered, never combinational from d.
  - ser_last=1 iff counter==SIZE-1.
  - Beat accepted (ser_ready=1 at a clk edge), not last: shift toward the output end (zero-fill) and counter += 1.
  - ser_ready=0: hold everything. ser_out, ser_last and ser_valid stay stable until accepted (AXI-style; no retraction).
  - Last beat accepted: next state IDLE, done=1 for exactly one cycle (the first IDLE cycle), counter=0.
- Latency:
  - First bit is visible the cycle after the load edge.
  - Minimum word time is SIZE cycles with ser_ready held at 1, plus one IDLE cycle before the next load (one-bubble turnaround). No back-to-back loads.
- Counter width is $clog2(SIZE) bits. It never wraps past SIZE-1; SIZE a power of two needs no special case.
- load_ready and ser_valid are derived from state only, never combinationally from load_valid or ser_ready.
- The captured word is unaffected by d changing after the load edge.

Decomposition:
- Shared package serializer_pkg:
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - localparam function for counter width.
- One natural sub-module: bit_counter #(WIDTH) with clk, reset, clear, inc, count, outputs terminal (count==MAX).
- Shift register and FSM live in the top module.

Test Plan:
1. Reset mid-word: with reset=0 asserted asynchronously mid-clock during a SHIFT of 0xFFFFFFFF at beat 10 -> ser_valid=0 and load_ready=1 without waiting for a clk edge; no done pulse; next load works normally.
2. Basic LSB-first: SIZE=8, load 0xA5, ser_ready=1 constant -> ser_out sequence 1,0,1,0,0,1,0,1 over 8 cycles; ser_last high only on beat 8; done pulses once the cycle after; load_ready=1 again.
3. MSB-first: SIZE=8, LSB_FIRST=0, load 0xA5 -> ser_out sequence 1,0,1,0,0,1,0,1 (MSB first); ser_last on 8th beat.
4. Backpressure: SIZE=32, load 0x80000001, ser_ready toggling 1,0,0,1,... -> ser_out/ser_last stable while ser_ready=0; exactly 32 accepted beats; first and last accepted bits =1, the rest 0; done once.
5. Load ignored while busy: during SHIFT of 0x0F (SIZE=8), drive load_valid=1 with d=0xFF -> ignored; output still 1,1,1,1,0,0,0,0; load_ready=0 throughout SHIFT.
6. Back-to-back words: load_valid held at 1 with d=0x3C then 0xC3 (SIZE=8) -> exactly one IDLE cycle between words; second word serializes as 1,1,0,0,0,0,1,1.
